// File: rtl/seq_display_pkg.sv
// Shared definitions for the sequence display path.
// Provides the display FSM state type, colour/LED sizing and the colour-code
// to one-hot LED decode that the player input-capture stage also uses.
package seq_display_pkg;

    localparam int unsigned ADDR_WIDTH      = 5;
    localparam int unsigned DATA_WIDTH      = 2;
    localparam int unsigned DIFICULTY_WIDTH = 2;
    localparam int unsigned NUM_COLORS      = 4;
    localparam int unsigned LED_W           = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ON,
        S_OFF,
        S_DONE
    } disp_state_t;

    // Colour code 0..3 -> LED bit 0..3.
    function automatic logic [LED_W-1:0] color_onehot(input logic [1:0] code);
        return LED_W'(1) << code;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter timing the LED on and off phases.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (count cleared)
//   load_i      - load load_val_i this cycle (takes priority over counting)
//   load_val_i  - value loaded; the phase lasts load_val_i + 1 cycles
//   expired_o   - count has reached zero (counter then holds at zero)
module tick_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/seq_display.sv
// Plays the stored colour sequence back on four LEDs.
// On start_i (accepted only when idle) it latches the length and difficulty,
// reads items 0..N-1 from the sequence memory, lights each colour for
// (4-difficulty)*TICK_DIV cycles followed by a TICK_DIV-cycle blank, then
// pulses done_o. All outputs are registered.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start_i                  - one-cycle start request
//   seq_len_i, difficulty_i  - latched at start
//   mem_rd_o, mem_addr_o     - memory read strobe / address (address holds)
//   mem_data_i               - read data, valid the cycle after mem_rd_o
//   led_o                    - one-hot LED drive
//   busy_o, done_o           - run in progress / one-cycle completion pulse
//   abort_i                  - only with SEQ_DISPLAY_ABORT_EN: return to idle,
//                              no done_o
module seq_display #(
    parameter int unsigned ADDR_WIDTH      = seq_display_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = seq_display_pkg::DATA_WIDTH,
    parameter int unsigned DIFICULTY_WIDTH = seq_display_pkg::DIFICULTY_WIDTH,
    parameter int unsigned TICK_DIV        = 12_500_000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic [ADDR_WIDTH:0]                seq_len_i,
    input  logic [DIFICULTY_WIDTH-1:0]         difficulty_i,
    output logic                               mem_rd_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    input  logic [DATA_WIDTH-1:0]              mem_data_i,
    output logic [seq_display_pkg::LED_W-1:0]  led_o,
    output logic                               busy_o,
`ifdef SEQ_DISPLAY_ABORT_EN
    input  logic                               abort_i,
`endif
    output logic                               done_o
);

    import seq_display_pkg::*;

    localparam int unsigned IDX_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(5 * TICK_DIV + 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(TICK_DIV - 1);

    disp_state_t                state_q, state_d;
    logic [IDX_W-1:0]           len_q, len_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [IDX_W-1:0]           idx_next;
    logic [DIFICULTY_WIDTH-1:0] diff_q, diff_d;
    logic [DATA_WIDTH-1:0]      colour_q, colour_d;
    logic                       rd_q, rd_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [LED_W-1:0]           led_q, led_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       cnt_load;
    logic [CNT_W-1:0]           cnt_load_val;
    logic                       cnt_expired;
    logic [31:0]                on_cycles;

    assign on_cycles = (32'd4 - 32'(diff_q)) * TICK_DIV;
    assign idx_next  = idx_q + IDX_W'(1);

    tick_counter #(
        .CNT_W(CNT_W)
    ) u_tick_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .expired_o  (cnt_expired)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        diff_d       = diff_q;
        colour_d     = colour_q;
        rd_d         = 1'b0;
        addr_d       = addr_q;
        led_d        = '0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    len_d   = seq_len_i;
                    diff_d  = difficulty_i;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                    // A zero-length run passes through S_FETCH without a read
                    // so that done_o still lands one edge after the start.
                    if (seq_len_i != '0) begin
                        rd_d   = 1'b1;
                        addr_d = '0;
                    end
                end
            end
            S_FETCH: begin
                if (len_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                colour_d     = mem_data_i;
                led_d        = color_onehot(mem_data_i[1:0]);
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(on_cycles - 32'd1);
                state_d      = S_ON;
            end
            S_ON: begin
                if (cnt_expired) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = OFF_LOAD;
                    state_d      = S_OFF;
                end else begin
                    led_d = color_onehot(colour_q[1:0]);
                end
            end
            S_OFF: begin
                if (cnt_expired) begin
                    idx_d = idx_next;
                    if (idx_next == len_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        rd_d    = 1'b1;
                        addr_d  = idx_next[ADDR_WIDTH-1:0];
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

`ifdef SEQ_DISPLAY_ABORT_EN
        if (abort_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            rd_d     = 1'b0;
            led_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            cnt_load = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            diff_q   <= '0;
            colour_q <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            led_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            colour_q <= colour_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem_rd_o   = rd_q;
    assign mem_addr_o = addr_q;
    assign led_o      = led_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_seq_display.sv
module tb_seq_display;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [5:0] seq_len_i = '0;
    logic [1:0] difficulty_i = '0;
    logic       mem_rd_o;
    logic [4:0] mem_addr_o;
    logic [1:0] mem_data_i = '0;
    logic [3:0] led_o;
    logic       busy_o;
    logic       done_o;
`ifdef SEQ_DISPLAY_ABORT_EN
    logic       abort_i = 1'b0;
`endif

    logic [1:0] mem [32];
    logic [4:0] last_addr = '0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int n;
        int d;
        bit preset;
        bit mid;
        int done_at;
    } vec_t;

    seq_display #(
        .ADDR_WIDTH      (5),
        .DATA_WIDTH      (2),
        .DIFICULTY_WIDTH (2),
        .TICK_DIV        (TDIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .seq_len_i    (seq_len_i),
        .difficulty_i (difficulty_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .led_o        (led_o),
        .busy_o       (busy_o),
`ifdef SEQ_DISPLAY_ABORT_EN
        .abort_i      (abort_i),
`endif
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
        else          mem_data_i <= 2'($urandom);
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", nm, k, act, exp);
        end
    endtask

    // Expected outputs k edges after the accepting edge, from the timing rules:
    // item i occupies k in [i*P, (i+1)*P): read at offset 0, LED lit for
    // offsets 2 .. 2+(4-d)*T-1, blank for the rest; done at N*P (or 1 if N=0).
    function automatic void expect_at(input int k, input int n, input int d,
                                      output logic [3:0] led, output logic rd,
                                      output logic [4:0] addr, output logic busy,
                                      output logic done);
        int p;
        int dk;
        int i;
        int j;
        logic [1:0] c;
        p    = 2 + (5 - d) * TDIV;
        dk   = (n == 0) ? 1 : n * p;
        led  = '0;
        rd   = 1'b0;
        addr = last_addr;
        busy = (k <= dk);
        done = (k == dk);
        if (n != 0 && k < n * p) begin
            i    = k / p;
            j    = k % p;
            rd   = (j == 0);
            addr = 5'(i);
            c    = mem[i];
            if (j >= 2 && j < 2 + (4 - d) * TDIV) led = 4'(1 << c);
        end else if (n != 0) begin
            addr = 5'(n - 1);
        end
    endfunction

    task automatic check_all(input string tag, input int k, input logic [3:0] el,
                             input logic erd, input logic [4:0] ea, input logic eb,
                             input logic ed);
        chk({tag, ".led"},  k, 32'(led_o),      32'(el));
        chk({tag, ".rd"},   k, 32'(mem_rd_o),   32'(erd));
        chk({tag, ".addr"}, k, 32'(mem_addr_o), 32'(ea));
        chk({tag, ".busy"}, k, 32'(busy_o),     32'(eb));
        chk({tag, ".done"}, k, 32'(done_o),     32'(ed));
    endtask

    // Entered at #1 after an edge with the DUT idle; leaves it idle one cycle
    // after done_o so a following call starts back-to-back.
    task automatic run_seq(input int n, input int d, input bit mid, output int done_seen);
        int p;
        int dk;
        logic [3:0] el;
        logic erd;
        logic [4:0] ea;
        logic eb;
        logic ed;
        p  = 2 + (5 - d) * TDIV;
        dk = (n == 0) ? 1 : n * p;
        seq_len_i    = 6'(n);
        difficulty_i = 2'(d);
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        done_seen = -1;
        for (int k = 0; k <= dk + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start_i      = 1'b0;
            seq_len_i    = 6'($urandom_range(0, 32));
            difficulty_i = 2'($urandom);
            if (mid && k <= dk && $urandom_range(0, 5) == 0) start_i = 1'b1;
            expect_at(k, n, d, el, erd, ea, eb, ed);
            check_all("run", k, el, erd, ea, eb, ed);
            if (done_o && done_seen < 0) done_seen = k;
        end
        start_i = 1'b0;
        if (n != 0) last_addr = 5'(n - 1);
    endtask

    task automatic load_mem(input bit preset);
        for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
        if (preset) begin
            mem[0] = 2'd2;
            mem[1] = 2'd0;
            mem[2] = 2'd3;
        end
    endtask

    initial begin
        vec_t vt[5];
        int ds;
        int n;
        int d;
        int p;

        vt[0] = '{n: 3,  d: 0, preset: 1'b1, mid: 1'b0, done_at: 66};
        vt[1] = '{n: 0,  d: 0, preset: 1'b0, mid: 1'b0, done_at: 1};
        vt[2] = '{n: 32, d: 3, preset: 1'b0, mid: 1'b0, done_at: 320};
        vt[3] = '{n: 1,  d: 1, preset: 1'b0, mid: 1'b1, done_at: 18};
        vt[4] = '{n: 5,  d: 2, preset: 1'b0, mid: 1'b1, done_at: 70};

        load_mem(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table runs, chained back-to-back.
        for (int t = 0; t < 5; t++) begin
            load_mem(vt[t].preset);
            run_seq(vt[t].n, vt[t].d, vt[t].mid, ds);
            chk("table.done_at", t, 32'(ds), 32'(vt[t].done_at));
        end

        // Randomized runs against the model, with stray start pulses.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            d = $urandom_range(0, 3);
            load_mem(1'b0);
            run_seq(n, d, 1'b1, ds);
            chk("rand.done_at", r, 32'(ds), 32'(n * (2 + (5 - d) * TDIV)));
        end

        // Reset while item 1 is lit.
        load_mem(1'b1);
        p = 2 + 5 * TDIV;
        seq_len_i    = 6'd3;
        difficulty_i = 2'd0;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (p + 4) @(posedge clk);
        #1;
        chk("rst.pre_led", p + 4, 32'(led_o), 32'(4'b0001));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("rst.after", 0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        last_addr = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            chk("rst.no_done", k, 32'({busy_o, done_o}), 32'd0);
        end
        run_seq(3, 0, 1'b0, ds);
        chk("rst.replay_done", 0, 32'(ds), 32'd66);

`ifdef SEQ_DISPLAY_ABORT_EN
        // Abort during the blank after item 0.
        load_mem(1'b1);
        seq_len_i    = 6'd3;
        difficulty_i = 2'd0;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("abort.pre", 19, 32'({busy_o, led_o}), 32'({1'b1, 4'b0000}));
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        check_all("abort.after", 0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            chk("abort.no_done", k, 32'({busy_o, done_o, led_o}), 32'd0);
        end
        last_addr = '0;
        run_seq(2, 1, 1'b0, ds);
        chk("abort.replay_done", 0, 32'(ds), 32'd36);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_display.md
# seq_display

Plays the stored colour sequence back to the player on four LEDs. The main game FSM pulses `start_i` on entry to SHOW_SEQUENCE. The block then reads items 0..N−1 from the sequence memory, lights the matching LED for a difficulty-dependent time, leaves a blank gap after each item, and pulses `done_o` so the FSM can move to GET_PLAYER_INPUT. It sits between the sequence memory and the LED outputs, downstream of the LFSR/sequence-append stage.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: sequence memory address width (32 items).
- `DATA_WIDTH`, 2: colour code width.
- `DIFICULTY_WIDTH`, 2: difficulty level width.
- `TICK_DIV`, 12_500_000: clock cycles per display tick. Must be ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: one-cycle start request. Ignored while `busy_o`=1.
- `seq_len_i`, in, ADDR_WIDTH+1: number of items to show, 0..32. Latched at start.
- `difficulty_i`, in, DIFICULTY_WIDTH: 0 (slow) to 3 (fast). Latched at start.
- `mem_rd_o`, out, 1: memory read strobe.
- `mem_addr_o`, out, ADDR_WIDTH: memory read address.
- `mem_data_i`, in, DATA_WIDTH: read data, valid exactly one cycle after `mem_rd_o`.
- `led_o`, out, 4: one-hot LED drive. Code 0→bit0 … code 3→bit3.
- `busy_o`, out, 1: high from the cycle after start acceptance until `done_o` inclusive.
- `done_o`, out, 1: one-cycle completion pulse.

## Operation
- States: S_IDLE, S_FETCH, S_WAIT, S_ON, S_OFF, S_DONE.
- S_IDLE: on `start_i`=1, latch `seq_len_i` and `difficulty_i`, clear index to 0, go to S_FETCH. If the latched length is 0, go to S_DONE instead.
- S_FETCH: `mem_rd_o`=1, `mem_addr_o`=index. Go to S_WAIT.
- S_WAIT: register `mem_data_i` into the colour register. Clear the cycle counter. Go to S_ON.
- S_ON: `led_o` = one-hot of the colour register. Stay for (4−difficulty)·TICK_DIV cycles, then go to S_OFF.
- S_OFF: `led_o`=0. Stay for TICK_DIV cycles. Then increment index; if index == length go to S_DONE, else go to S_FETCH.
- S_DONE: `done_o`=1 for one cycle, then S_IDLE.
- Index and comparison use ADDR_WIDTH+1 bits, so length 32 terminates correctly with no wrap to 0.
- `start_i` in any state other than S_IDLE is ignored.
- `led_o` is 0 in every state except S_ON.
- `mem_addr_o` holds the last driven address when `mem_rd_o`=0.
- Reset, including mid-sequence: next state S_IDLE; all outputs 0, index 0, counter 0. No `done_o` is produced.

## Timing
- All outputs are registered.
- Reset values: `led_o`=0, `mem_rd_o`=0, `mem_addr_o`=0, `busy_o`=0, `done_o`=0.
- Start sampled at edge E: `mem_rd_o` is high in the cycle after E, and the first LED lights at edge E+2.
- Per-item duration is P = 2 + (5−d)·TICK_DIV cycles.
- S_DONE is entered at edge E + N·P. For N=0 it is entered at edge E+1.
- Back-to-back: a new `start_i` is accepted in the first S_IDLE cycle after `done_o`.

## Configuration
- `SEQ_DISPLAY_ABORT_EN` defined: adds port `abort_i` (in, 1).
  - `abort_i`=1 in any non-IDLE state forces S_IDLE at the next edge.
  - `led_o`=0 and `busy_o`=0 from that edge; no `done_o` pulse.
  - `abort_i` has priority over normal transitions; reset has priority over abort.
- Macro undefined: no `abort_i` port. A sequence always runs to `done_o`.

## Structure
- Shared package additions:
  - `disp_state_t` enum for the six states.
  - `NUM_COLORS`=4.
  - `LED_W`=4.
  - A colour-code→one-hot decode function, reused by the input-capture stage.
  - Existing `ADDR_WIDTH`, `DATA_WIDTH` and `DIFICULTY_WIDTH` are reused.
- One sub-module, `tick_counter`:
  - Loadable down-counter with a `load` input and terminal value `(5·TICK_DIV)`-wide, plus an `expired` flag.
  - Used for both the ON and OFF durations.

## Test plan
- TICK_DIV=4, memory {2,0,3}, `seq_len_i`=3, d=0, start at edge E:
  - `led_o`=4'b0100 during edges E+2..E+17, then 0 during E+18..E+21.
  - `mem_addr_o` reads 0, 1, 2.
  - `done_o` is a single pulse at edge E+66.
- `seq_len_i`=0: `done_o` at E+1, `mem_rd_o` never asserted, `led_o` stays 0.
- `seq_len_i`=32, d=3, TICK_DIV=2:
  - Addresses 0..31 read in order, each exactly once.
  - P=6, so `done_o` at E+192 with no extra read at address 0.
- `start_i` pulsed again mid-sequence: ignored, and timing matches an undisturbed run.
  - Second start in the cycle after `done_o`: accepted.
- `rst` during S_ON of item 1: all outputs 0 next edge, no `done_o`.
  - A subsequent start replays from address 0.
- With `SEQ_DISPLAY_ABORT_EN`: `abort_i` during S_OFF gives `busy_o`=0 and `led_o`=0 next edge, with no `done_o` pulse.
